// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, one-cycle press/release strobes.
// Optional auto-repeat while held is compiled in with `define BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic       btn_release,
    output logic [1:0] dbg_state_o
);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > REP_MAX) ? DEBOUNCE_CYCLES : REP_MAX;
`else
    localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_pulse: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_pulse: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] count_q;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    // rep_first_q marks that the initial REPEAT_DELAY has elapsed in this hold.
    logic [CNT_W-1:0] rep_q;
    logic             rep_first_q;
    logic [CNT_W-1:0] rep_last;
    assign rep_last = rep_first_q ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
`endif

    assign dbg_state_o = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            count_q     <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_q <= PRESS_WAIT;
                        count_q <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (count_q == DEB_LAST) begin
                        state_q   <= HELD;
                        count_q   <= '0;
                        btn_level <= 1'b1;
                        btn_pulse <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                        rep_q       <= '0;
                        rep_first_q <= 1'b0;
`endif
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_q <= RELEASE_WAIT;
                        count_q <= CNT_ONE;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                        rep_q       <= '0;
                        rep_first_q <= 1'b0;
                    end else if (rep_q == rep_last) begin
                        btn_pulse   <= 1'b1;
                        rep_q       <= '0;
                        rep_first_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + CNT_ONE;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to 1 returns to HELD silently; any repeat timing restarts.
                    if (sync2_q) begin
                        state_q <= HELD;
                        count_q <= '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                        rep_q       <= '0;
                        rep_first_q <= 1'b0;
`endif
                    end else if (count_q == DEB_LAST) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed press/release/reset scenarios plus random button
// traffic, all checked every cycle against a run-length reference model of the button.
module tb_btn_debounce_pulse;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       btn_level;
    logic       btn_pulse;
    logic       btn_release;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Reference: btn_in history two deep, debounced level, length of the current run of
    // samples disagreeing with the level, and consecutive cycles spent firmly held.
    logic m_pipe0, m_pipe1, m_level, m_pulse, m_release;
    int   m_run, m_hold;
    int   pulse_cnt = 0;
    int   rel_cnt   = 0;

    always #5 clock = ~clock;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic b);
        logic s;
        if (r) begin
            m_pipe0 = 1'b0; m_pipe1 = 1'b0; m_level = 1'b0;
            m_pulse = 1'b0; m_release = 1'b0; m_run = 0; m_hold = 0;
        end else begin
            s = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = b;
            m_pulse = 1'b0;
            m_release = 1'b0;
            if (s != m_level) begin
                m_run++;
                m_hold = 0;
                if (m_run == D) begin
                    m_level = s;
                    m_run = 0;
                    if (s) m_pulse = 1'b1;
                    else   m_release = 1'b1;
                end
            end else begin
                if (m_level && m_run == 0) begin
                    m_hold++;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) m_pulse = 1'b1;
`endif
                end else begin
                    m_hold = 0;
                end
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic b);
        @(negedge clock);
        reset  = r;
        btn_in = b;
        @(posedge clock);
        model_edge(r, b);
        #1;
        check("level", btn_level, m_level);
        check("pulse", btn_pulse, m_pulse);
        check("release", btn_release, m_release);
        check("pulse_release_exclusive", btn_pulse & btn_release, 1'b0);
        pulse_cnt += int'(btn_pulse);
        rel_cnt   += int'(btn_release);
    endtask

    initial begin
        int p0, r0, len;
        logic lvl;
        logic [7:0] pat;
        reset  = 1'b1;
        btn_in = 1'b0;
        model_edge(1'b1, 1'b0);

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("reset_level", btn_level, 1'b0);
        check("reset_pulse", btn_pulse, 1'b0);
        check("reset_release", btn_release, 1'b0);

        // Steady press: strobe only after edge E0+5
        r0 = rel_cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check("press_early_pulse", btn_pulse, 1'b0);
            check("press_early_level", btn_level, 1'b0);
        end
        step(1'b0, 1'b1);
        check("press_latency_pulse", btn_pulse, 1'b1);
        check("press_latency_level", btn_level, 1'b1);
        step(1'b0, 1'b1);
        check("press_pulse_one_cycle", btn_pulse, 1'b0);
        check_int("press_no_release", rel_cnt - r0, 0);

        // Steady release with identical latency
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("release_early", btn_release, 1'b0);
        end
        step(1'b0, 1'b0);
        check("release_latency", btn_release, 1'b1);
        check("release_level", btn_level, 1'b0);
        step(1'b0, 1'b0);
        check("release_one_cycle", btn_release, 1'b0);

        // Short bounce of 3 cycles: nothing happens
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check_int("short_bounce_pulses", pulse_cnt - p0, 0);
        check("short_bounce_level", btn_level, 1'b0);

        // Bouncy press 1,1,0,1,1,... then clean release
        p0 = pulse_cnt;
        r0 = rel_cnt;
        pat = 8'b1111_1011;
        for (int i = 0; i < 8; i++) step(1'b0, pat[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check_int("bouncy_press_pulses", pulse_cnt - p0, 1);
        check("bouncy_press_level", btn_level, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        check_int("bouncy_release_count", rel_cnt - r0, 1);
        check("bouncy_release_level", btn_level, 1'b0);

        // Reset while PRESS_WAIT holds count 2, button kept pressed
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("midreset_level", btn_level, 1'b0);
        check("midreset_pulse", btn_pulse, 1'b0);
        check("midreset_release", btn_release, 1'b0);
        check_int("midreset_no_strobe", pulse_cnt - p0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check("after_reset_early", btn_pulse, 1'b0);
        end
        step(1'b0, 1'b1);
        check("after_reset_pulse", btn_pulse, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // Long hold of 30 cycles past acceptance
        p0 = pulse_cnt;
        for (int i = 0; i < 36; i++) step(1'b0, 1'b1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        check_int("long_hold_pulses", pulse_cnt - p0, 8);
`else
        check_int("long_hold_pulses", pulse_cnt - p0, 1);
`endif
        p0 = pulse_cnt;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        check_int("release_stops_repeat", pulse_cnt - p0, 0);
        check("long_hold_released", btn_level, 1'b0);

        // Random button traffic with occasional resets
        lvl = 1'b0;
        for (int seg = 0; seg < 250; seg++) begin
            lvl = ($urandom_range(0, 3) == 0) ? lvl : ~lvl;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, lvl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
